// File: rtl/flash_prefetch_buffer.sv
// Single-line prefetch buffer between the core instruction bus and the SPI flash controller.
// Build macro CRITICAL_WORD_FIRST_EN: fill starts at the requested byte and ready is issued early.
module flash_prefetch_buffer #(
  parameter int ADDR_WIDTH  = 24,
  parameter int LINE_BYTES  = 8,
  parameter int OFFSET_BITS = $clog2(LINE_BYTES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  chipSel,
  input  logic                  readMem,
  input  logic [ADDR_WIDTH-1:0] addressBus,
  output logic [7:0]            dataOut,
  output logic                  ready,
  input  logic                  flush,
  output logic                  ctrlChipSel,
  output logic                  ctrlReadMem,
  output logic [ADDR_WIDTH-1:0] ctrlAddress,
  input  logic [7:0]            ctrlDataIn,
  input  logic                  ctrlReady
);

  localparam int TAG_W = ADDR_WIDTH - OFFSET_BITS;
  localparam logic [OFFSET_BITS-1:0] LAST_IDX = OFFSET_BITS'(LINE_BYTES - 1);
  localparam logic [OFFSET_BITS-1:0] ONE      = OFFSET_BITS'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_GAP  = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t                 r_state;
  logic                   r_valid;
  logic                   r_flush_pend;
  logic                   r_ready;
  logic                   r_ctrl_cs;
  logic [TAG_W-1:0]       r_tag;
  logic [OFFSET_BITS-1:0] r_cnt;
  logic [7:0]             r_line [LINE_BYTES];
  logic [7:0]             r_dout;
  logic [ADDR_WIDTH-1:0]  r_ctrl_addr;

  logic                   w_req;
  logic                   w_hit;
  logic [TAG_W-1:0]       w_tag;
  logic [OFFSET_BITS-1:0] w_off;
  logic [OFFSET_BITS-1:0] w_fill_off;
  logic [OFFSET_BITS-1:0] w_next_off;
  logic [OFFSET_BITS-1:0] w_first_off;

  assign w_req = chipSel & readMem;
  assign w_tag = addressBus[ADDR_WIDTH-1:OFFSET_BITS];
  assign w_off = addressBus[OFFSET_BITS-1:0];
  // A flush in the same cycle as a request forces the miss path.
  assign w_hit = r_valid & ~flush & (w_tag == r_tag);

`ifdef CRITICAL_WORD_FIRST_EN
  logic [OFFSET_BITS-1:0] r_start;
  assign w_fill_off  = r_start + r_cnt;
  assign w_first_off = w_off;
`else
  logic [7:0] w_byte;
  assign w_fill_off  = r_cnt;
  assign w_first_off = '0;
  // The final byte is written at the same edge dataOut is loaded, so bypass it.
  assign w_byte = (w_off == w_fill_off) ? ctrlDataIn : r_line[w_off];
`endif
  assign w_next_off = w_fill_off + ONE;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_valid      <= 1'b0;
      r_flush_pend <= 1'b0;
      r_ready      <= 1'b0;
      r_ctrl_cs    <= 1'b0;
      r_tag        <= '0;
      r_cnt        <= '0;
      r_dout       <= '0;
      r_ctrl_addr  <= '0;
      for (int i = 0; i < LINE_BYTES; i++) r_line[i] <= '0;
`ifdef CRITICAL_WORD_FIRST_EN
      r_start      <= '0;
`endif
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (flush) r_valid <= 1'b0;
          if (w_req) begin
            if (w_hit) begin
              r_dout  <= r_line[w_off];
              r_ready <= 1'b1;
              r_state <= S_RESP;
            end else begin
              r_valid      <= 1'b0;
              r_tag        <= w_tag;
              r_cnt        <= '0;
              r_flush_pend <= 1'b0;
              r_ctrl_cs    <= 1'b1;
              r_ctrl_addr  <= {w_tag, w_first_off};
`ifdef CRITICAL_WORD_FIRST_EN
              r_start      <= w_off;
`endif
              r_state      <= S_FILL;
            end
          end
        end

        S_FILL: begin
          if (flush) r_flush_pend <= 1'b1;
          if (ctrlReady) begin
            r_line[w_fill_off] <= ctrlDataIn;
            r_ctrl_cs          <= 1'b0;
`ifdef CRITICAL_WORD_FIRST_EN
            if ((r_cnt == '0) && w_req) begin
              r_dout  <= ctrlDataIn;
              r_ready <= 1'b1;
            end
`endif
            if (r_cnt == LAST_IDX) begin
              r_valid      <= ~(r_flush_pend | flush);
              r_flush_pend <= 1'b0;
`ifdef CRITICAL_WORD_FIRST_EN
              r_state      <= S_IDLE;
`else
              if (w_req) begin
                r_dout  <= w_byte;
                r_ready <= 1'b1;
                r_state <= S_RESP;
              end else begin
                r_state <= S_IDLE;
              end
`endif
            end else begin
              r_cnt       <= r_cnt + ONE;
              r_ctrl_addr <= {r_tag, w_next_off};
              r_state     <= S_GAP;
            end
          end
        end

        // One idle cycle so the controller sees a fresh request edge.
        S_GAP: begin
          if (flush) r_flush_pend <= 1'b1;
          r_ctrl_cs <= 1'b1;
          r_state   <= S_FILL;
        end

        S_RESP: begin
          if (flush) r_valid <= 1'b0;
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign dataOut     = r_dout;
  assign ready       = r_ready;
  assign ctrlChipSel = r_ctrl_cs;
  assign ctrlReadMem = r_ctrl_cs;
  assign ctrlAddress = r_ctrl_addr;

endmodule

// File: tb/tb_flash_prefetch_buffer.sv
// Directed bench for flash_prefetch_buffer with a behavioural SPI flash controller model.
module tb_flash_prefetch_buffer;

  localparam int AW = 24;
`ifdef CRITICAL_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          chipSel;
  logic          readMem;
  logic [AW-1:0] addressBus;
  logic [7:0]    dataOut;
  logic          ready;
  logic          flush;
  logic          ctrlChipSel;
  logic          ctrlReadMem;
  logic [AW-1:0] ctrlAddress;
  logic [7:0]    ctrlDataIn;
  logic          ctrlReady;

  int n_tests = 0;
  int n_fail  = 0;
  logic [AW-1:0] addr_log[$];
  int gap_log[$];
  int ready_cnt;
  int low_run;

  flash_prefetch_buffer #(.ADDR_WIDTH(AW), .LINE_BYTES(8)) dut (
    .clk(clk), .rst(rst), .chipSel(chipSel), .readMem(readMem),
    .addressBus(addressBus), .dataOut(dataOut), .ready(ready), .flush(flush),
    .ctrlChipSel(ctrlChipSel), .ctrlReadMem(ctrlReadMem), .ctrlAddress(ctrlAddress),
    .ctrlDataIn(ctrlDataIn), .ctrlReady(ctrlReady)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] fbyte(input logic [AW-1:0] a);
    return 8'h10 + a[7:0];
  endfunction

  function automatic logic [AW-1:0] exp_addr(input logic [AW-1:0] a, input int k);
    int o;
    o = ((CWF ? int'(a[2:0]) : 0) + k) % 8;
    return (a & ~24'h7) | AW'(o);
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Controller model: accepts a request, answers three cycles later, then waits for chipSel to drop.
  initial begin
    bit busy;
    int wt;
    ctrlReady = 1'b0; ctrlDataIn = 8'h00; busy = 1'b0; wt = 0; ready_cnt = 0; low_run = 0;
    forever begin
      @(posedge clk); #1;
      ctrlReady = 1'b0;
      if (rst) begin
        busy = 1'b0;
      end else if (busy) begin
        if (wt == 0) begin
          ctrlReady  = 1'b1;
          ctrlDataIn = fbyte(ctrlAddress);
          busy       = 1'b0;
          ready_cnt++;
        end else begin
          wt--;
        end
      end else if (ctrlChipSel && ctrlReadMem) begin
        busy = 1'b1;
        wt   = 2;
        addr_log.push_back(ctrlAddress);
        gap_log.push_back(low_run);
      end
      if (ctrlChipSel) low_run = 0;
      else low_run++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic settle();
    int quiet = 0;
    for (int i = 0; i < 300 && quiet < 4; i++) begin
      @(posedge clk); #2;
      if (ctrlChipSel) quiet = 0;
      else quiet++;
    end
    check_val("settle", (quiet >= 4) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic do_read(input logic [AW-1:0] a, output logic [7:0] d, output int cyc);
    bit got;
    @(posedge clk); #2;
    addr_log.delete(); gap_log.delete();
    chipSel = 1'b1; readMem = 1'b1; addressBus = a;
    got = 1'b0; cyc = 0; d = 8'h00;
    while (!got && cyc < 300) begin
      @(posedge clk); #2;
      cyc++;
      if (ready) begin
        got = 1'b1;
        d   = dataOut;
      end
    end
    chipSel = 1'b0; readMem = 1'b0;
    check_val("read_ready_seen", {31'd0, got}, 32'd1);
    @(posedge clk); #2;
    check_val("ready_one_cycle", {31'd0, ready}, 32'd0);
    settle();
  endtask

  task automatic check_fill(input string tag, input logic [AW-1:0] a);
    check_val({tag, "_nreq"}, addr_log.size(), 32'd8);
    for (int k = 0; k < 8 && k < addr_log.size(); k++) begin
      check_val($sformatf("%s_addr%0d", tag, k), addr_log[k], exp_addr(a, k));
      if (k > 0) check_val($sformatf("%s_gap%0d", tag, k), gap_log[k], 32'd1);
    end
  endtask

  initial begin
    logic [7:0] d;
    int cyc;
    int base;
    int rdy_seen;

    rst = 1'b1; chipSel = 1'b0; readMem = 1'b0; flush = 1'b0; addressBus = '0;
    repeat (3) @(posedge clk);
    #2;
    check_val("rst_dataOut", dataOut, 32'h0);
    check_val("rst_ready", ready, 32'h0);
    check_val("rst_ctrlChipSel", ctrlChipSel, 32'h0);
    check_val("rst_ctrlReadMem", ctrlReadMem, 32'h0);
    check_val("rst_ctrlAddress", ctrlAddress, 32'h0);
    rst = 1'b0;

    do_read(24'h000003, d, cyc);
    check_val("miss3_data", d, 32'h13);
    check_fill("miss3", 24'h000003);

    do_read(24'h000005, d, cyc);
    check_val("hit5_data", d, 32'h15);
    check_val("hit5_latency", cyc, 32'd1);
    check_val("hit5_nreq", addr_log.size(), 32'd0);

    // chipSel without readMem must be ignored.
    @(posedge clk); #2;
    addr_log.delete();
    chipSel = 1'b1; readMem = 1'b0; addressBus = 24'h000005;
    rdy_seen = 0;
    repeat (6) begin
      @(posedge clk); #2;
      if (ready) rdy_seen++;
    end
    chipSel = 1'b0;
    check_val("cs_only_no_ready", rdy_seen, 32'd0);
    check_val("cs_only_no_ctrl", addr_log.size(), 32'd0);

    do_read(24'h000008, d, cyc);
    check_val("miss8_data", d, 32'h18);
    check_fill("miss8", 24'h000008);

    do_read(24'h000001, d, cyc);
    check_val("miss1_data", d, 32'h11);
    check_fill("miss1", 24'h000001);

    do_read(24'h00000A, d, cyc);
    check_val("missA_data", d, 32'h1A);
    do_read(24'h00000B, d, cyc);
    check_val("hitB_data", d, 32'h1B);
    check_val("hitB_nreq", addr_log.size(), 32'd0);

    @(posedge clk); #2;
    flush = 1'b1;
    @(posedge clk); #2;
    flush = 1'b0;
    do_read(24'h00000A, d, cyc);
    check_val("flushA_data", d, 32'h1A);
    check_fill("flushA", 24'h00000A);

    // Reset in the middle of a fill.
    @(posedge clk); #2;
    addr_log.delete(); gap_log.delete();
    base = ready_cnt;
    chipSel = 1'b1; readMem = 1'b1; addressBus = 24'h000012;
    cyc = 0;
    while ((ready_cnt - base) < 3 && cyc < 300) begin
      @(posedge clk); #2;
      cyc++;
    end
    check_val("rstmid_reached", ready_cnt - base, 32'd3);
    rst = 1'b1; chipSel = 1'b0; readMem = 1'b0;
    @(posedge clk); #2;
    check_val("rstmid_dataOut", dataOut, 32'h0);
    check_val("rstmid_ready", ready, 32'h0);
    check_val("rstmid_ctrlChipSel", ctrlChipSel, 32'h0);
    check_val("rstmid_ctrlReadMem", ctrlReadMem, 32'h0);
    check_val("rstmid_ctrlAddress", ctrlAddress, 32'h0);
    rst = 1'b0;
    do_read(24'h000012, d, cyc);
    check_val("refetch_data", d, 32'h22);
    check_fill("refetch", 24'h000012);

`ifndef CRITICAL_WORD_FIRST_EN
    // Core withdraws mid-fill: line still becomes valid, no ready issued.
    @(posedge clk); #2;
    base = ready_cnt;
    chipSel = 1'b1; readMem = 1'b1; addressBus = 24'h000023;
    cyc = 0;
    while ((ready_cnt - base) < 2 && cyc < 300) begin
      @(posedge clk); #2;
      cyc++;
    end
    chipSel = 1'b0; readMem = 1'b0;
    rdy_seen = 0;
    cyc = 0;
    while ((ready_cnt - base) < 8 && cyc < 300) begin
      @(posedge clk); #2;
      cyc++;
      if (ready) rdy_seen++;
    end
    repeat (3) begin
      @(posedge clk); #2;
      if (ready) rdy_seen++;
    end
    check_val("drop_fill_done", ready_cnt - base, 32'd8);
    check_val("drop_no_ready", rdy_seen, 32'd0);
    do_read(24'h000021, d, cyc);
    check_val("drop_hit_data", d, 32'h31);
    check_val("drop_hit_latency", cyc, 32'd1);
    check_val("drop_hit_nreq", addr_log.size(), 32'd0);
`else
    // Critical word first, plus a second request stalled behind the background fill.
    @(posedge clk); #2;
    addr_log.delete(); gap_log.delete();
    base = ready_cnt;
    chipSel = 1'b1; readMem = 1'b1; addressBus = 24'h000006;
    rdy_seen = 0; cyc = 0;
    while (rdy_seen == 0 && cyc < 300) begin
      @(posedge clk); #2;
      cyc++;
      if (ready) begin
        rdy_seen = 1;
        d = dataOut;
      end
    end
    check_val("cwf_first_data", d, 32'h16);
    check_val("cwf_first_after", ready_cnt - base, 32'd1);
    addressBus = 24'h000002;
    rdy_seen = 0; cyc = 0;
    while (rdy_seen == 0 && cyc < 300) begin
      @(posedge clk); #2;
      cyc++;
      if (ready) begin
        rdy_seen = 1;
        d = dataOut;
      end
    end
    chipSel = 1'b0; readMem = 1'b0;
    check_val("cwf_second_data", d, 32'h12);
    check_val("cwf_second_after_fill", ready_cnt - base, 32'd8);
    settle();
    check_fill("cwf", 24'h000006);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/flash_prefetch_buffer.md
Name: flash_prefetch_buffer

Overview:
- Single-line read buffer between the AFTAB core instruction-memory bus and spi_flash_controller.
- Serves core byte reads from a LINE_BYTES-byte line held in registers.
- On a miss, refills the whole aligned line through sequential byte reads to the SPI flash controller.
- Sequential instruction fetch therefore pays the slow SPI transaction cost only once per line.

Parameters:
- ADDR_WIDTH, 24, byte address width on both sides.
- LINE_BYTES, 8, bytes per line; power of two, 2..64.
- OFFSET_BITS, $clog2(LINE_BYTES), byte-offset field width (derived).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- chipSel  input  1  core-side select (decoder CS_IM)
- readMem  input  1  core read strobe
- addressBus  input  ADDR_WIDTH  core byte address
- dataOut  output  8  byte returned to core, registered
- ready  output  1  one-cycle pulse; dataOut valid in the same cycle
- flush  input  1  invalidate line
- ctrlChipSel  output  1  request to spi_flash_controller
- ctrlReadMem  output  1  read strobe to controller, equal to ctrlChipSel
- ctrlAddress  output  ADDR_WIDTH  byte address to controller
- ctrlDataIn  input  8  byte from controller
- ctrlReady  input  1  controller completion pulse; ctrlDataIn valid in the same cycle

Behaviour:
- Reset (synchronous, any state including mid-fill):
  - State goes to IDLE; valid=0; tag=0; line bytes=0; fill counter=0.
  - dataOut=0, ready=0, ctrlChipSel=ctrlReadMem=0, ctrlAddress=0.
  - The controller transaction is abandoned. The controller shares rst, so both sides restart clean.
- Core request = chipSel & readMem. Core holds addressBus stable until ready.
- chipSel with readMem=0 is ignored and never produces ready.
- tag = addressBus[ADDR_WIDTH-1:OFFSET_BITS]; offset = addressBus[OFFSET_BITS-1:0].
- hit = valid & (tag == stored tag).
- IDLE:
  - Request with hit: latch the byte into dataOut and go to RESP.
  - Request with miss: valid<=0, store tag, counter<=0, go to FILL.
  - No request: stay in IDLE.
- FILL:
  - ctrlChipSel=1.
  - ctrlAddress = {stored tag, counter} (line base first, ascending).
  - ctrlAddress is stable until ctrlReady.
  - On ctrlReady: line[counter] <= ctrlDataIn, counter increments.
    - ctrlChipSel drops for exactly one cycle (GAP) before the next byte so the controller sees a new request.
  - After byte LINE_BYTES-1 is stored: valid<=1, dataOut<=line[requested offset], go to RESP.
- GAP: ctrlChipSel=0 for one cycle, then return to FILL.
- RESP: ready=1 for one cycle, then go to IDLE.
- A request still asserted in IDLE after RESP is served again (hit). This is harmless for reads.
- Latency:
  - Hit: request sampled in cycle N, ready in cycle N+1.
  - Miss: ready one cycle after the cycle in which the last ctrlReady is sampled.
- Core drops its request mid-fill: the fill still completes and the line becomes valid, but no ready is issued.
  - Implementation: RESP is entered only if the request is still present; otherwise go to IDLE.
- flush:
  - In IDLE or RESP: valid<=0 at the next edge.
  - During FILL/GAP: the fill completes but valid stays 0 (flush-pending flag); the pending core request is still answered from the filled line.
  - flush together with a request in IDLE: flush wins and the request is treated as a miss.
- Tag compare and offset select are full-width; there is no wrap past the line. The counter stops at LINE_BYTES-1.

Optional Feature:
- CRITICAL_WORD_FIRST_EN defined:
  - The fill starts at the requested offset and wraps modulo LINE_BYTES, so ctrlAddress = {tag, (startOffset+counter) mod LINE_BYTES}.
  - ready pulses one cycle after the requested byte arrives; the remaining bytes fill in the background.
  - A new core request during the background fill stalls (no ready) until the fill ends, then is evaluated as in IDLE.
- Not defined: fill is always line-base-first and ready is issued only after the full line.

Test Plan:
- Reset, then read 0x000003 with flash bytes 0x00..0x07 = 0x10..0x17:
  - Eight controller requests at 0x000000..0x000007, each separated by a one-cycle ctrlChipSel low.
  - Then ready with dataOut=0x13.
- Immediately read 0x000005: hit, ready exactly 1 cycle after the request, dataOut=0x15, no ctrlChipSel activity.
- Read 0x000008: miss, refill 0x000008..0x00000F. A subsequent read of 0x000001 misses again (single line).
- Assert flush for 1 cycle, then read 0x00000A: full refill occurs, correct byte returned.
- Assert rst after the 3rd ctrlReady of a fill:
  - All outputs are 0 next cycle, valid=0.
  - A new read of the same line refetches from byte 0.
- With CRITICAL_WORD_FIRST_EN, read 0x000006:
  - Controller addresses in order 6,7,0,1,...,5.
  - ready one cycle after the first ctrlReady with dataOut=0x16.
  - A read of 0x000002 issued before the fill ends gets ready only after the fill completes.
